// File: rtl/keypad_pkg.sv
// Shared types, row-drive constants and column decode for the keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } state_t;

   typedef logic [3:0] key_code_t;

   localparam logic [3:0] ROW_0    = 4'b1110;
   localparam logic [3:0] ROW_1    = 4'b1101;
   localparam logic [3:0] ROW_2    = 4'b1011;
   localparam logic [3:0] ROW_3    = 4'b0111;
   localparam logic [3:0] COL_IDLE = 4'b1111;

   function automatic logic [3:0] row_drive(input logic [1:0] idx);
      logic [3:0] r;
      case (idx)
         2'd0:    r = ROW_0;
         2'd1:    r = ROW_1;
         2'd2:    r = ROW_2;
         default: r = ROW_3;
      endcase
      return r;
   endfunction

   // Returns {valid, idx}; valid only when exactly one column is pulled low.
   function automatic logic [2:0] col_decode(input logic [3:0] c);
      logic [2:0] d;
      case (c)
         4'b1110: d = 3'b100;
         4'b1101: d = 3'b101;
         4'b1011: d = 3'b110;
         4'b0111: d = 3'b111;
         default: d = 3'b000;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Row dwell divider: strobe is high on the last cycle of every SCAN_DIV-cycle dwell.
module keypad_scan_timer #(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic strobe
);

   localparam int unsigned DW = $clog2(SCAN_DIV);

   logic [DW-1:0] div;

   assign strobe = (div == DW'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)
         div <= '0;
      else if (strobe)
         div <= '0;
      else
         div <= div + 1'b1;
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner with debounce and a one-deep event buffer.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key stays held.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 4
`ifdef KEYPAD_REPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY = 500,
   parameter int unsigned REPEAT_RATE  = 100
`endif
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] row,
   input  logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_held,
   output logic       overflow
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);

   logic          strobe;
   state_t        state, state_n;
   logic [1:0]    row_idx, row_idx_n;
   logic [3:0]    cap_col, cap_col_n;
   key_code_t     key_cap, key_cap_n;
   logic [CW-1:0] count, count_n, count_inc;
   logic [2:0]    dec;
   logic          emit;

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RW   = $clog2(RMAX + 1);

   logic [RW-1:0] rep_cnt, rep_cnt_n, rep_inc;
   logic          rep_first, rep_first_n;
`endif

   keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .strobe (strobe)
   );

   assign row       = row_drive(row_idx);
   assign key_held  = (state == ST_HELD) || (state == ST_RELEASE);
   assign dec       = col_decode(col);
   assign count_inc = (count == '1) ? count : count + 1'b1;
`ifdef KEYPAD_REPEAT_EN
   assign rep_inc   = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;
`endif

   always_comb begin
      state_n   = state;
      row_idx_n = row_idx;
      cap_col_n = cap_col;
      key_cap_n = key_cap;
      count_n   = count;
      emit      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_n   = rep_cnt;
      rep_first_n = rep_first;
`endif
      if (strobe) begin
         case (state)
            ST_SCAN: begin
               if (dec[2]) begin
                  cap_col_n = col;
                  key_cap_n = {row_idx, dec[1:0]};
                  count_n   = CW'(1);
                  // A single-sample debounce completes on the capturing strobe itself.
                  if (DEBOUNCE_CNT == 1) begin
                     emit    = 1'b1;
                     state_n = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                     rep_cnt_n   = '0;
                     rep_first_n = 1'b0;
`endif
                  end else begin
                     state_n = ST_DEBOUNCE;
                  end
               end else begin
                  row_idx_n = row_idx + 1'b1;
               end
            end
            ST_DEBOUNCE: begin
               if (col == cap_col) begin
                  count_n = count_inc;
                  if (count_inc == CW'(DEBOUNCE_CNT)) begin
                     emit    = 1'b1;
                     state_n = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                     rep_cnt_n   = '0;
                     rep_first_n = 1'b0;
`endif
                  end
               end else begin
                  state_n   = ST_SCAN;
                  row_idx_n = row_idx + 1'b1;
               end
            end
            ST_HELD: begin
               if (col == COL_IDLE) begin
                  if (DEBOUNCE_CNT == 1) begin
                     state_n   = ST_SCAN;
                     row_idx_n = row_idx + 1'b1;
                  end else begin
                     count_n = CW'(1);
                     state_n = ST_RELEASE;
                  end
               end else begin
`ifdef KEYPAD_REPEAT_EN
                  rep_cnt_n = rep_inc;
                  if (!rep_first && (rep_inc >= RW'(REPEAT_DELAY))) begin
                     emit        = 1'b1;
                     rep_cnt_n   = '0;
                     rep_first_n = 1'b1;
                  end else if (rep_first && (rep_inc >= RW'(REPEAT_RATE))) begin
                     emit      = 1'b1;
                     rep_cnt_n = '0;
                  end
`endif
               end
            end
            ST_RELEASE: begin
               if (col == COL_IDLE) begin
                  count_n = count_inc;
                  if (count_inc == CW'(DEBOUNCE_CNT)) begin
                     state_n   = ST_SCAN;
                     row_idx_n = row_idx + 1'b1;
                  end
               end else begin
                  state_n = ST_HELD;
               end
            end
            default: state_n = ST_SCAN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_SCAN;
         row_idx <= '0;
         cap_col <= COL_IDLE;
         key_cap <= '0;
         count   <= '0;
      end else begin
         state   <= state_n;
         row_idx <= row_idx_n;
         cap_col <= cap_col_n;
         key_cap <= key_cap_n;
         count   <= count_n;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt   <= '0;
         rep_first <= 1'b0;
      end else begin
         rep_cnt   <= rep_cnt_n;
         rep_first <= rep_first_n;
      end
   end
`endif

   // An event loads when the buffer is empty or being drained this cycle; otherwise it is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_code  <= '0;
         key_valid <= 1'b0;
         overflow  <= 1'b0;
      end else if (emit && (!key_valid || key_ready)) begin
         key_code  <= key_cap_n;
         key_valid <= 1'b1;
      end else begin
         if (emit)
            overflow <= 1'b1;
         if (key_valid && key_ready)
            key_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE_CNT=3); a keypad model drives col from row.
module tb_keypad_scan_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       key_held;
   logic       overflow;

   logic       key_down;
   logic [3:0] key_num;
   logic       raw_en;
   logic [3:0] raw_col;

   int errors;
   int checks;

   keypad_scan_ctrl #(
      .SCAN_DIV     (4),
      .DEBOUNCE_CNT (3)
`ifdef KEYPAD_REPEAT_EN
      ,
      .REPEAT_DELAY (2),
      .REPEAT_RATE  (1)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_held  (key_held),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pressed key shorts its column low only while its row is driven.
   always_comb begin
      col = 4'hF;
      if (raw_en)
         col = raw_col;
      else if (key_down && (row[key_num[3:2]] == 1'b0))
         col[key_num[1:0]] = 1'b0;
   end

   // Advance n rising edges, then sample 1 time unit later.
   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns just after edge E0: the first cycle of a fresh dwell, rst low.
   task automatic do_reset();
      rst       = 1'b1;
      key_down  = 1'b0;
      raw_en    = 1'b0;
      key_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (row !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b exp 1110", row); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", key_valid); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b exp 0", key_held); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
      checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h exp 0", key_code); end
   endtask

   task automatic test_single_event();
      do_reset();
      key_num  = 4'd6;
      key_down = 1'b1;
      adv(15);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b exp 0", key_valid); end
      adv(1);
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", key_valid); end
      checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL single_code: got %h exp 6", key_code); end
      checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL single_held: got %b exp 1", key_held); end
      checks++; if (row !== 4'b1101) begin errors++; $display("FAIL single_row_frozen: got %b exp 1101", row); end
      key_down = 1'b0;
      adv(1);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b exp 0", key_valid); end
      adv(10);
      checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL single_held_release: got %b exp 1", key_held); end
      adv(1);
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL single_held_clear: got %b exp 0", key_held); end
      checks++; if (row !== 4'b1011) begin errors++; $display("FAIL single_row_resume: got %b exp 1011", row); end
   endtask

   task automatic test_bounce();
      do_reset();
      key_num  = 4'd0;
      key_down = 1'b1;
      adv(4);
      checks++; if (row !== 4'b1110) begin errors++; $display("FAIL bounce_capture_row: got %b exp 1110", row); end
      key_down = 1'b0;
      adv(4);
      checks++; if (row !== 4'b1101) begin errors++; $display("FAIL bounce_row_next: got %b exp 1101", row); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held: got %b exp 0", key_held); end
      adv(4);
      checks++; if (row !== 4'b1011) begin errors++; $display("FAIL bounce_row_rotate: got %b exp 1011", row); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_no_event: got %b exp 0", key_valid); end
   endtask

   task automatic test_ghost();
      do_reset();
      raw_en  = 1'b1;
      raw_col = 4'b1001;
      adv(4);
      checks++; if (row !== 4'b1101) begin errors++; $display("FAIL ghost_row1: got %b exp 1101", row); end
      adv(4);
      checks++; if (row !== 4'b1011) begin errors++; $display("FAIL ghost_row2: got %b exp 1011", row); end
      adv(4);
      checks++; if (row !== 4'b0111) begin errors++; $display("FAIL ghost_row3: got %b exp 0111", row); end
      adv(4);
      checks++; if (row !== 4'b1110) begin errors++; $display("FAIL ghost_row_wrap: got %b exp 1110", row); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ghost_no_event: got %b exp 0", key_valid); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL ghost_held: got %b exp 0", key_held); end
      raw_en = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      key_ready = 1'b0;
      key_num   = 4'd0;
      key_down  = 1'b1;
      adv(12);
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL ovf_first_valid: got %b exp 1", key_valid); end
      checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL ovf_first_code: got %h exp 0", key_code); end
      key_down = 1'b0;
      adv(12);
      key_num  = 4'd15;
      key_down = 1'b1;
      adv(19);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b exp 0", overflow); end
      adv(1);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", overflow); end
      checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL ovf_code_kept: got %h exp 0", key_code); end
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid_hold: got %b exp 1", key_valid); end
      key_ready = 1'b1;
      adv(1);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ovf_valid_drop: got %b exp 0", key_valid); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
      key_down = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      key_ready = 1'b0;
      key_num   = 4'd0;
      key_down  = 1'b1;
      adv(12);
      key_down = 1'b0;
      adv(12);
      key_num  = 4'd15;
      key_down = 1'b1;
      adv(19);
      key_ready = 1'b1;
      adv(1);
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b exp 1", key_valid); end
      checks++; if (key_code !== 4'hF) begin errors++; $display("FAIL b2b_code: got %h exp f", key_code); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_overflow: got %b exp 0", overflow); end
      adv(1);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b exp 0", key_valid); end
      key_down = 1'b0;
   endtask

   task automatic test_reset_abort();
      do_reset();
      key_num  = 4'd9;
      key_down = 1'b1;
      adv(13);
      checks++; if (row !== 4'b1011) begin errors++; $display("FAIL abort_row_frozen: got %b exp 1011", row); end
      rst = 1'b1;
      adv(1);
      checks++; if (row !== 4'b1110) begin errors++; $display("FAIL abort_row: got %b exp 1110", row); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b exp 0", key_valid); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL abort_held: got %b exp 0", key_held); end
      rst      = 1'b0;
      key_down = 1'b0;
      adv(24);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL abort_no_event: got %b exp 0", key_valid); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b exp 0", key_held); end
   endtask

`ifdef KEYPAD_REPEAT_EN
   task automatic test_repeat();
      do_reset();
      key_num  = 4'd5;
      key_down = 1'b1;
      adv(16);
      checks++; if (key_valid !== 1'b1 || key_code !== 4'h5) begin errors++; $display("FAIL rep_press: got %b/%h exp 1/5", key_valid, key_code); end
      adv(4);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rep_gap: got %b exp 0", key_valid); end
      for (int i = 0; i < 5; i++) begin
         adv(4);
         checks++; if (key_valid !== 1'b1 || key_code !== 4'h5) begin errors++; $display("FAIL rep_event%0d: got %b/%h exp 1/5", i, key_valid, key_code); end
      end
      key_down = 1'b0;
   endtask
`else
   task automatic test_no_repeat();
      do_reset();
      key_num  = 4'd5;
      key_down = 1'b1;
      adv(16);
      checks++; if (key_valid !== 1'b1 || key_code !== 4'h5) begin errors++; $display("FAIL norep_press: got %b/%h exp 1/5", key_valid, key_code); end
      for (int i = 0; i < 5; i++) begin
         adv(4);
         checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL norep_quiet%0d: got %b exp 0", i, key_valid); end
      end
      checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL norep_held: got %b exp 1", key_held); end
      key_down = 1'b0;
   endtask
`endif

   initial begin
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      key_down  = 1'b0;
      key_num   = 4'd0;
      raw_en    = 1'b0;
      raw_col   = 4'hF;
      key_ready = 1'b1;
      test_reset();
      test_single_event();
      test_bounce();
      test_ghost();
      test_overflow();
      test_back_to_back();
      test_reset_abort();
`ifdef KEYPAD_REPEAT_EN
      test_repeat();
`else
      test_no_repeat();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
